chip8_timers: RTL

CHIP8_TIMERS -- requirements
Module: chip8_timers

---
 rtl/chip8_pkg.sv | 12 +
 rtl/chip8_down_timer.sv | 21 ++
 rtl/chip8_timers.sv | 79 +++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared widths and helpers for the CHIP-8 delay/sound timer block.
package chip8_pkg;

   localparam int TIMER_W    = 8;
   localparam int TONE_CNT_W = 16;

   // Saturating decrement: a timer parked at zero never wraps to 255.
   function automatic logic [TIMER_W-1:0] dec_sat(input logic [TIMER_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

endpackage

// File: rtl/chip8_down_timer.sv
// chip8_down_timer: one 60 Hz CHIP-8 timer; a load wins over a same-cycle tick.
module chip8_down_timer
   import chip8_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               we,
   input  logic [TIMER_W-1:0] wdata,
   output logic [TIMER_W-1:0] count
);

   always_ff @(posedge clk or posedge reset)
      if (reset)
         count <= '0;
      else if (we)
         count <= wdata;
      else if (tick)
         count <= dec_sat(count);

endmodule

// File: rtl/chip8_timers.sv
// chip8_timers: CHIP-8 delay and sound timers with vsync tick and speaker drive.
// Define CHIP8_TONE_EN for a TONE_HALF square-wave tone; otherwise spkr follows vsync.
module chip8_timers
   import chip8_pkg::*;
#(
   parameter int TONE_HALF = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               dt_we,
   input  logic               st_we,
   input  logic [TIMER_W-1:0] wdata,
   output logic [TIMER_W-1:0] dt_rdata,
   output logic               tick,
   output logic               beep,
   output logic               spkr
);

   logic               vsync_q;
   logic [TIMER_W-1:0] st_count;

   if (TONE_HALF < 1 || TONE_HALF > 65535) begin : g_bad_tone_half
      $error("chip8_timers: TONE_HALF must be 1..65535");
   end

   always_ff @(posedge clk or posedge reset)
      if (reset)
         vsync_q <= 1'b0;
      else
         vsync_q <= vsync;

   assign tick = vsync & ~vsync_q;

   chip8_down_timer u_delay (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .we    (dt_we),
      .wdata (wdata),
      .count (dt_rdata)
   );

   chip8_down_timer u_sound (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .we    (st_we),
      .wdata (wdata),
      .count (st_count)
   );

   assign beep = |st_count;

`ifdef CHIP8_TONE_EN
   logic [TONE_CNT_W-1:0] tone_cnt;
   logic                  phase;

   // Tone restarts from phase 0 every time beep rises.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tone_cnt <= '0;
         phase    <= 1'b0;
      end else if (!beep) begin
         tone_cnt <= '0;
         phase    <= 1'b0;
      end else if (tone_cnt == TONE_CNT_W'(TONE_HALF - 1)) begin
         tone_cnt <= '0;
         phase    <= ~phase;
      end else begin
         tone_cnt <= tone_cnt + 1'b1;
      end

   assign spkr = beep & phase;
`else
   assign spkr = beep & vsync;
`endif

endmodule
